// File: rtl/inst_word_loader.sv
// rtl/inst_word_loader.sv - packs a handshaked byte stream into 32-bit instruction words
// and holds the CPU stalled until the program load completes.
module inst_word_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic [ADDR_W:0]   words_loaded,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_WRITE,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        byte_idx;
  logic [31:0]       shift_word;
  logic [31:0]       merged;
  logic              req_q;
  logic              req_qq;
  logic              rise;
  logic              accept;
  logic              full;
  logic              start;

  // Two-stage edge detect: a rising load_req reaches the FSM one cycle after it is registered.
  assign rise   = req_q && !req_qq;
  assign accept = byte_valid && (state == S_ASSEMBLE);
  assign full   = (words_loaded == FULL_COUNT);
  assign start  = ((state == S_IDLE) && load_req) || ((state == S_RUN) && rise);

  assign byte_ready = (state == S_ASSEMBLE);
  assign mem_we     = (state == S_WRITE);
  assign cpu_run    = (state == S_RUN);

  always_comb begin
    merged = shift_word;
    if (accept) merged[8*byte_idx +: 8] = byte_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     state_nxt = load_req ? S_ASSEMBLE : S_RUN;
      S_ASSEMBLE: begin
        if (accept && (byte_idx == 2'd3)) begin
          state_nxt = S_WRITE;
        end else if (!load_req) begin
          // A byte taken in the same cycle load_req falls still forms a partial word.
          state_nxt = ((byte_idx != 2'd0) || accept) ? S_WRITE : S_RUN;
        end
      end
      S_WRITE:    state_nxt = ((word_addr == LAST_ADDR) || !load_req) ? S_RUN : S_ASSEMBLE;
      S_RUN:      if (rise) state_nxt = S_ASSEMBLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      word_addr    <= '0;
      byte_idx     <= '0;
      shift_word   <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      req_q        <= 1'b0;
      req_qq       <= 1'b0;
    end else begin
      state  <= state_nxt;
      req_q  <= load_req;
      req_qq <= req_q;
      if (start) begin
        word_addr    <= '0;
        byte_idx     <= '0;
        shift_word   <= '0;
        words_loaded <= '0;
        overflow     <= 1'b0;
      end else begin
        case (state)
          S_ASSEMBLE: begin
            if (accept) begin
              shift_word <= merged;
              byte_idx   <= byte_idx + 2'd1;
            end
            if (state_nxt == S_WRITE) begin
              mem_addr  <= word_addr;
              mem_wdata <= merged;
            end
          end
          S_WRITE: begin
            word_addr  <= word_addr + 1'b1;
            byte_idx   <= '0;
            shift_word <= '0;
            if (!full) words_loaded <= words_loaded + 1'b1;
          end
          S_RUN: begin
            if (full && load_req && byte_valid) overflow <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_word_loader.sv
// tb/tb_inst_word_loader.sv - directed self-checking bench for inst_word_loader.
module tb_inst_word_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst_n;
  logic              load_req;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic [ADDR_W:0]   words_loaded;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  inst_word_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .words_loaded (words_loaded),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer, valid left high.
  task automatic send_byte(input logic [7:0] b);
    int n;
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  logic [7:0]  t4_bytes[12];
  int          t4_gaps[12];
  logic [31:0] t4_words[3];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    load_req   = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(byte_ready), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_run", 32'(cpu_run), 32'd0);
    check_eq("rst_wl", 32'(words_loaded), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Test 1: full-word load
    clear_log();
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'h10);
    send_byte(8'h00);
    check_eq("t1_we", 32'(mem_we), 32'd1);
    check_eq("t1_addr", 32'(mem_addr), 32'd0);
    check_eq("t1_data", mem_wdata, 32'h00100513);
    byte_valid = 1'b0;
    load_req   = 1'b0;
    @(negedge clk);
    check_eq("t1_run", 32'(cpu_run), 32'd1);
    check_eq("t1_wl", 32'(words_loaded), 32'd1);
    check_eq("t1_nwr", 32'(wr_addr.size()), 32'd1);

    // Test 3: fill and overflow
    clear_log();
    load_req = 1'b1;
    for (int i = 0; i < 4*DEPTH; i++) send_byte(8'(i));
    byte_data = 8'hEE;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check_eq("t3_run", 32'(cpu_run), 32'd1);
    check_eq("t3_wl", 32'(words_loaded), 32'd32);
    check_eq("t3_ovf", 32'(overflow), 32'd1);
    check_eq("t3_nwr", 32'(wr_addr.size()), 32'd32);
    for (int k = 0; k < DEPTH && k < wr_addr.size(); k++) begin
      check_eq($sformatf("t3_addr%0d", k), wr_addr[k], 32'(k));
      check_eq($sformatf("t3_data%0d", k), wr_data[k],
               {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end

    // Test 5: reload from RUN
    clear_log();
    load_req = 1'b0;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    check_eq("t5_run_e1", 32'(cpu_run), 32'd1);
    @(negedge clk);
    check_eq("t5_run_e2", 32'(cpu_run), 32'd0);
    check_eq("t5_ready_e2", 32'(byte_ready), 32'd1);
    check_eq("t5_wl_clr", 32'(words_loaded), 32'd0);
    check_eq("t5_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    byte_valid = 1'b0;
    check_eq("t5_addr", 32'(mem_addr), 32'd0);
    check_eq("t5_data", mem_wdata, 32'hFFFFFFFF);
    @(negedge clk);
    check_eq("t5_wl", 32'(words_loaded), 32'd1);
    load_req = 1'b0;
    @(negedge clk);
    check_eq("t5_run_idx0", 32'(cpu_run), 32'd1);
    check_eq("t5_nwr", 32'(wr_addr.size()), 32'd1);

    // Test 2: partial word
    clear_log();
    load_req = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_valid = 1'b0;
    load_req   = 1'b0;
    @(negedge clk);
    check_eq("t2_we", 32'(mem_we), 32'd1);
    check_eq("t2_addr", 32'(mem_addr), 32'd0);
    check_eq("t2_data", mem_wdata, 32'h0000BBAA);
    check_eq("t2_run1", 32'(cpu_run), 32'd0);
    @(negedge clk);
    check_eq("t2_run2", 32'(cpu_run), 32'd1);
    check_eq("t2_wl", 32'(words_loaded), 32'd1);

    // Test 4: backpressure and gaps, valid held through WRITE when gap is zero
    clear_log();
    for (int i = 0; i < 12; i++) begin
      t4_bytes[i] = 8'(i + 1);
      t4_gaps[i]  = i % 3;
    end
    t4_words[0] = 32'h04030201;
    t4_words[1] = 32'h08070605;
    t4_words[2] = 32'h0C0B0A09;
    load_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (t4_gaps[i] != 0) begin
        byte_valid = 1'b0;
        repeat (t4_gaps[i]) @(negedge clk);
      end
      send_byte(t4_bytes[i]);
    end
    byte_valid = 1'b0;
    @(negedge clk);
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t4_nwr", 32'(wr_addr.size()), 32'd3);
    for (int k = 0; k < 3 && k < wr_addr.size(); k++) begin
      check_eq($sformatf("t4_addr%0d", k), wr_addr[k], 32'(k));
      check_eq($sformatf("t4_data%0d", k), wr_data[k], t4_words[k]);
    end
    check_eq("t4_run", 32'(cpu_run), 32'd1);

    // Test 6: asynchronous reset mid-word
    load_req = 1'b1;
    send_byte(8'h55);
    send_byte(8'h66);
    byte_valid = 1'b0;
    clear_log();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_ready", 32'(byte_ready), 32'd0);
    check_eq("t6_we", 32'(mem_we), 32'd0);
    check_eq("t6_run", 32'(cpu_run), 32'd0);
    check_eq("t6_addr", 32'(mem_addr), 32'd0);
    check_eq("t6_data", mem_wdata, 32'd0);
    check_eq("t6_wl", 32'(words_loaded), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("t6_nwr_rst", 32'(wr_addr.size()), 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    byte_valid = 1'b0;
    load_req   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t6_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      check_eq("t6_waddr", wr_addr[0], 32'd0);
      check_eq("t6_wdata", wr_data[0], 32'h44332211);
    end
    check_eq("t6_run_end", 32'(cpu_run), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
